// File: rtl/cp0_exc_ctrl_if.sv
// CP0 exception-control port bundle: mtc0/mfc0 access, commit-point exception inputs, handler redirect outputs.
// Purely combinational wiring; the master side drives requests and the slave side answers in the same cycle.
// No backpressure: every input is sampled each rising clock edge.
interface cp0_exc_ctrl_if;
  logic        WE;
  logic [4:0]  CP0Addr;
  logic [31:0] CP0In;
  logic [31:0] CP0Out;
  logic [31:0] VPC;
  logic        BDIn;
  logic [4:0]  ExcCodeIn;
  logic [5:0]  HWInt;
  logic        EXLClr;
  logic        Req;
  logic [31:0] EPCOut;

  modport master (
    output WE, CP0Addr, CP0In, VPC, BDIn, ExcCodeIn, HWInt, EXLClr,
    input  CP0Out, Req, EPCOut
  );

  modport slave (
    input  WE, CP0Addr, CP0In, VPC, BDIn, ExcCodeIn, HWInt, EXLClr,
    output CP0Out, Req, EPCOut
  );
endinterface

// File: rtl/cp0_exc_ctrl.sv
// CP0 Status/Cause/EPC/PRId block: raises Req for enabled interrupts or sync exceptions and records handler state.
// Req and CP0Out are same-cycle combinational; register updates land on the next rising clk.
// No backpressure: a taken exception silently drops any same-cycle mtc0 write and eret.
module cp0_exc_ctrl #(
  parameter logic [4:0]  SR_ADDR    = 5'd12,
  parameter logic [4:0]  CAUSE_ADDR = 5'd13,
  parameter logic [4:0]  EPC_ADDR   = 5'd14,
  parameter logic [4:0]  PRID_ADDR  = 5'd15,
  parameter logic [31:0] PRID_VAL   = 32'h0000_4D49
) (
  input logic           clk,
  input logic           rst_n,
  cp0_exc_ctrl_if.slave cp0
);

  logic [5:0]  im_q, im_d;
  logic        exl_q, exl_d;
  logic        ie_q, ie_d;
  logic        bd_q, bd_d;
  logic [5:0]  ip_q, ip_d;
  logic [4:0]  exc_code_q, exc_code_d;
  logic [31:0] epc_q, epc_d;

  logic        int_req;
  logic        exc_req;
  logic        req;
  logic [29:0] epc_word;
  logic [31:0] sr_val;
  logic [31:0] cause_val;
  logic [31:0] rd_dat;

  // EXL masks both sources, so nothing new is taken while a handler runs.
  always_comb begin
    int_req = ie_q & ~exl_q & (|(cp0.HWInt & im_q));
    exc_req = ~exl_q & (cp0.ExcCodeIn != 5'd0);
    req     = int_req | exc_req;
  end

  // Word-granular EPC: subtracting one word from VPC[31:2] equals (VPC-4)[31:2], wrapping naturally.
  always_comb begin
    epc_word = cp0.BDIn ? (cp0.VPC[31:2] - 30'd1) : cp0.VPC[31:2];
  end

  always_comb begin
    im_d       = im_q;
    exl_d      = exl_q;
    ie_d       = ie_q;
    bd_d       = bd_q;
    ip_d       = cp0.HWInt;
    exc_code_d = exc_code_q;
    epc_d      = epc_q;
    if (req) begin
      exl_d      = 1'b1;
      exc_code_d = int_req ? 5'd0 : cp0.ExcCodeIn;
      bd_d       = cp0.BDIn;
      epc_d      = {epc_word, 2'b00};
    end else begin
      if (cp0.WE) begin
        if (cp0.CP0Addr == SR_ADDR) begin
          im_d  = cp0.CP0In[15:10];
          exl_d = cp0.CP0In[1];
          ie_d  = cp0.CP0In[0];
        end else if (cp0.CP0Addr == EPC_ADDR) begin
          epc_d = {cp0.CP0In[31:2], 2'b00};
        end
      end
      // eret overrides an mtc0 to SR on the EXL bit only.
      if (cp0.EXLClr) begin
        exl_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      im_q       <= '0;
      exl_q      <= 1'b0;
      ie_q       <= 1'b0;
      bd_q       <= 1'b0;
      ip_q       <= '0;
      exc_code_q <= '0;
      epc_q      <= '0;
    end else begin
      im_q       <= im_d;
      exl_q      <= exl_d;
      ie_q       <= ie_d;
      bd_q       <= bd_d;
      ip_q       <= ip_d;
      exc_code_q <= exc_code_d;
      epc_q      <= epc_d;
    end
  end

  always_comb begin
    sr_val    = {16'h0000, im_q, 8'h00, exl_q, ie_q};
    cause_val = {bd_q, 15'h0000, ip_q, 3'b000, exc_code_q, 2'b00};
    rd_dat    = 32'h0000_0000;
    case (cp0.CP0Addr)
      SR_ADDR:    rd_dat = sr_val;
      CAUSE_ADDR: rd_dat = cause_val;
      EPC_ADDR:   rd_dat = epc_q;
      PRID_ADDR:  rd_dat = PRID_VAL;
      default:    rd_dat = 32'h0000_0000;
    endcase
  end

  assign cp0.Req    = req;
  assign cp0.EPCOut = epc_q;
  assign cp0.CP0Out = rd_dat;

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Bench for cp0_exc_ctrl: directed literal scenarios, then randomized traffic against a word-level register model.
// The model keeps SR/Cause/EPC as whole 32-bit words updated with masks and arithmetic.
`timescale 1ns/1ps
module tb_cp0_exc_ctrl;

  localparam logic [4:0]  A_SR    = 5'd12;
  localparam logic [4:0]  A_CAUSE = 5'd13;
  localparam logic [4:0]  A_EPC   = 5'd14;
  localparam logic [4:0]  A_PRID  = 5'd15;
  localparam logic [31:0] PRID    = 32'h0000_4D49;
  localparam logic [31:0] SR_MASK = 32'h0000_FC03;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_err;

  cp0_exc_ctrl_if bus ();

  cp0_exc_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .cp0   (bus.slave)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  logic [31:0] m_sr, m_cause, m_epc;

  function automatic logic m_int();
    return m_sr[0] && !m_sr[1] && ((bus.HWInt & m_sr[15:10]) != 6'd0);
  endfunction

  function automatic logic m_req();
    return m_int() || (!m_sr[1] && bus.ExcCodeIn != 5'd0);
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == A_SR)    return m_sr;
    if (a == A_CAUSE) return m_cause;
    if (a == A_EPC)   return m_epc;
    if (a == A_PRID)  return PRID;
    return 32'h0;
  endfunction

  function automatic logic [31:0] nx_sr();
    logic [31:0] v;
    v = m_sr;
    if (m_req()) return v | 32'h2;
    if (bus.WE && bus.CP0Addr == A_SR) v = bus.CP0In & SR_MASK;
    if (bus.EXLClr) v = v & ~32'h2;
    return v;
  endfunction

  function automatic logic [31:0] nx_cause();
    logic [31:0] ip;
    logic [31:0] code;
    ip = 32'(bus.HWInt) << 10;
    if (m_req()) begin
      code = m_int() ? 32'h0 : 32'(bus.ExcCodeIn);
      return (32'(bus.BDIn) << 31) | ip | (code << 2);
    end
    return (m_cause & 32'h8000_007C) | ip;
  endfunction

  function automatic logic [31:0] nx_epc();
    logic [31:0] pc;
    if (m_req()) begin
      pc = bus.BDIn ? bus.VPC - 32'd4 : bus.VPC;
      return pc & ~32'h3;
    end
    if (bus.WE && bus.CP0Addr == A_EPC) return bus.CP0In & ~32'h3;
    return m_epc;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_sr    <= 32'h0;
      m_cause <= 32'h0;
      m_epc   <= 32'h0;
    end else begin
      m_sr    <= nx_sr();
      m_cause <= nx_cause();
      m_epc   <= nx_epc();
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model comparison every cycle, after the stimulus has settled.
  always @(negedge clk) begin
    #2;
    if (rst_n === 1'b1) begin
      chk("req_vs_model", 32'(bus.Req), 32'(m_req()));
      chk("epcout_vs_model", bus.EPCOut, m_epc);
      chk("cp0out_vs_model", bus.CP0Out, m_read(bus.CP0Addr));
    end
  end

  task automatic drive(input logic we, input logic [4:0] addr, input logic [31:0] din,
                       input logic [31:0] vpc, input logic bd, input logic [4:0] exc,
                       input logic [5:0] hw, input logic clr);
    @(negedge clk);
    bus.WE        = we;
    bus.CP0Addr   = addr;
    bus.CP0In     = din;
    bus.VPC       = vpc;
    bus.BDIn      = bd;
    bus.ExcCodeIn = exc;
    bus.HWInt     = hw;
    bus.EXLClr    = clr;
    #1;
  endtask

  // Async reset pulse placed strictly between clock edges.
  task automatic reset_pulse();
    #2;
    rst_n = 1'b0;
    #6;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] din;
    logic [31:0] vpc;
    logic [4:0]  addr;
    n_chk = 0;
    n_err = 0;
    rst_n = 1'b0;

    drive(0, A_SR, 0, 0, 0, 0, 0, 0);
    chk("reset_sr", bus.CP0Out, 32'h0);
    chk("reset_req", 32'(bus.Req), 32'h0);
    chk("reset_epcout", bus.EPCOut, 32'h0);
    drive(0, A_PRID, 0, 0, 0, 0, 0, 0);
    chk("reset_prid", bus.CP0Out, PRID);
    rst_n = 1'b1;

    // Interrupt taken with IM[10] and IE set.
    drive(1, A_SR, 32'h0000_0401, 0, 0, 0, 0, 0);
    drive(0, A_EPC, 0, 32'h0000_3010, 0, 0, 6'b000001, 0);
    chk("int_req_same_cycle", 32'(bus.Req), 32'h1);
    drive(0, A_CAUSE, 0, 0, 0, 0, 0, 0);
    chk("int_epc", bus.EPCOut, 32'h0000_3010);
    chk("int_cause", bus.CP0Out, 32'h0000_0400);
    chk("int_req_masked_by_exl", 32'(bus.Req), 32'h0);
    drive(0, A_SR, 0, 0, 0, 0, 0, 0);
    chk("int_sr_exl", bus.CP0Out, 32'h0000_0403);

    // Sync exception in a delay slot.
    drive(0, A_SR, 0, 0, 0, 0, 0, 1);
    drive(0, A_CAUSE, 0, 32'h0000_3024, 1, 5'd12, 0, 0);
    chk("exc_req", 32'(bus.Req), 32'h1);
    drive(0, A_CAUSE, 0, 0, 0, 0, 0, 0);
    chk("exc_cause_bd", bus.CP0Out, 32'h8000_0030);
    chk("exc_epc_bd", bus.EPCOut, 32'h0000_3020);

    // Interrupt beats a simultaneous exception; eret then clears EXL.
    drive(0, A_SR, 0, 0, 0, 0, 0, 1);
    drive(0, A_CAUSE, 0, 32'h0000_3100, 0, 5'd10, 6'b000001, 0);
    chk("prio_req", 32'(bus.Req), 32'h1);
    drive(0, A_CAUSE, 0, 0, 0, 0, 0, 1);
    chk("prio_cause_code0", bus.CP0Out, 32'h0000_0400);
    drive(0, A_SR, 0, 0, 0, 0, 0, 0);
    chk("eret_sr", bus.CP0Out, 32'h0000_0401);
    chk("eret_epc_kept", bus.EPCOut, 32'h0000_3100);

    // mtc0 EPC dropped while Req, accepted on retry.
    drive(1, A_EPC, 32'h0000_4003, 32'h0000_3200, 0, 0, 6'b000001, 0);
    chk("drop_req", 32'(bus.Req), 32'h1);
    drive(0, A_EPC, 0, 0, 0, 0, 0, 0);
    chk("drop_epc", bus.EPCOut, 32'h0000_3200);
    drive(1, A_EPC, 32'h0000_4003, 0, 0, 0, 0, 0);
    drive(0, A_EPC, 0, 0, 0, 0, 0, 0);
    chk("retry_epc", bus.EPCOut, 32'h0000_4000);

    // VPC-4 wraps at zero.
    drive(0, A_SR, 0, 0, 0, 0, 0, 1);
    drive(0, A_SR, 0, 32'h0, 1, 5'd4, 0, 0);
    drive(1, A_EPC, 32'h0000_3010, 0, 0, 0, 0, 0);
    chk("wrap_epc", bus.EPCOut, 32'hFFFF_FFFC);
    drive(0, A_SR, 0, 0, 0, 0, 0, 0);
    chk("pre_reset_sr", bus.CP0Out, 32'h0000_0403);

    // Reset mid-handling, observed without any clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_sr", bus.CP0Out, 32'h0);
    bus.CP0Addr = A_CAUSE;
    #1;
    chk("arst_cause", bus.CP0Out, 32'h0);
    bus.CP0Addr = A_EPC;
    #1;
    chk("arst_epc", bus.CP0Out, 32'h0);
    chk("arst_epcout", bus.EPCOut, 32'h0);
    bus.CP0Addr = 5'd7;
    #1;
    chk("arst_unmapped", bus.CP0Out, 32'h0);
    bus.CP0Addr = A_PRID;
    #1;
    chk("arst_prid", bus.CP0Out, PRID);
    #1;
    rst_n = 1'b1;
    drive(0, A_SR, 0, 0, 0, 0, 6'h3F, 0);
    chk("post_reset_no_int", 32'(bus.Req), 32'h0);

    for (int i = 0; i < 3000; i++) begin
      din = $urandom;
      if ($urandom_range(1, 0) == 1) begin
        din[1] = 1'b0;
        din[0] = 1'b1;
      end
      case ($urandom_range(5, 0))
        0: addr = A_SR;
        1: addr = A_CAUSE;
        2: addr = A_EPC;
        3: addr = A_PRID;
        default: addr = 5'($urandom);
      endcase
      vpc = ($urandom_range(15, 0) == 0) ? 32'($urandom_range(7, 0)) : $urandom;
      drive(($urandom_range(3, 0) == 0), addr, din, vpc, 1'($urandom),
            ($urandom_range(7, 0) == 0) ? 5'($urandom) : 5'd0,
            ($urandom_range(3, 0) == 0) ? 6'($urandom) : 6'd0,
            ($urandom_range(5, 0) == 0));
      if ($urandom_range(149, 0) == 0) reset_pulse();
    end

    @(negedge clk);
    #3;
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
